// File: rtl/psram_wr_burst_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : psram_wr_burst_sched_if
// Purpose  : FIFO read port and pSRAM command/data port of the burst scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface psram_wr_burst_sched_if #(
  parameter int ADDR_W = 23
);
  logic              fifo_prog_empty;
  logic              fifo_rempty;
  logic              fifo_ren;
  logic [15:0]       fifo_rdata;
  logic              psram_req;
  logic [ADDR_W-1:0] psram_addr;
  logic              psram_ack;
  logic [15:0]       psram_wdata;
  logic              psram_wvalid;
  logic              psram_wready;

  modport master (
    input  fifo_prog_empty, fifo_rempty, fifo_rdata, psram_ack, psram_wready,
    output fifo_ren, psram_req, psram_addr, psram_wdata, psram_wvalid
  );

  modport slave (
    output fifo_prog_empty, fifo_rempty, fifo_rdata, psram_ack, psram_wready,
    input  fifo_ren, psram_req, psram_addr, psram_wdata, psram_wvalid
  );
endinterface
`default_nettype wire

// File: rtl/psram_wr_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : psram_wr_burst_sched
// Purpose  : Schedules pSRAM write bursts from the video FIFO, tracks the frame
//            position; define PSRAM_PINGPONG_EN for two alternating buffers.
// Revision : 1.0 - initial release
// ============================================================================
module psram_wr_burst_sched #(
  parameter int BURST_LEN   = 32,
  parameter int ADDR_W      = 23,
  parameter int FRAME_WORDS = 518400,
  parameter int BASE0       = 0,
  parameter int BASE1       = 524288
) (
  input  wire logic               rclk,
  input  wire logic               reset_n,
  input  wire logic               enable,
  input  wire logic               frame_start,
  psram_wr_burst_sched_if.master  bus,
  output logic                    buf_sel,
  output logic                    frame_done,
  output logic                    underrun,
  output logic                    frame_err
);

  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam int RD_W  = $clog2(BURST_LEN) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_BURST = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  w_next_cnt;
  logic [RD_W-1:0]   rd_left_q, rd_left_d;
  logic              buf_sel_q, buf_sel_d;
  logic              resync_pend_q, resync_pend_d;
  logic              underrun_q, underrun_d;
  logic              frame_err_q, frame_err_d;
  logic              frame_done_q, frame_done_d;
  logic              psram_req_q, psram_req_d;
  logic [ADDR_W-1:0] psram_addr_q, psram_addr_d;
  logic [ADDR_W-1:0] w_base;

  logic [15:0]       skid_q [2];
  logic [15:0]       skid_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;

  logic              w_ren;
  logic              w_wvalid;
  logic [15:0]       w_wdata;
  logic              w_pop;
  logic              w_pop_buf;
  logic              w_push;

  // An empty skid buffer passes the FIFO word straight through, so a word
  // read in one cycle can be presented to the controller in the next.
  assign w_wvalid  = (occ_q != 2'd0) || inflight_q;
  assign w_wdata   = (occ_q != 2'd0) ? skid_q[rd_ptr_q] :
                     (inflight_q ? bus.fifo_rdata : 16'h0000);
  assign w_pop     = w_wvalid && bus.psram_wready;
  assign w_pop_buf = w_pop && (occ_q != 2'd0);
  assign w_push    = inflight_q && !(w_pop && (occ_q == 2'd0));
  assign w_ren     = (state_q == S_BURST) && (rd_left_q != '0) && !bus.fifo_rempty &&
                     (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2);

  assign w_base     = buf_sel_q ? ADDR_W'(BASE1) : ADDR_W'(BASE0);
  assign w_next_cnt = word_cnt_q + CNT_W'(BURST_LEN);

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    rd_left_d     = rd_left_q;
    buf_sel_d     = buf_sel_q;
    resync_pend_d = resync_pend_q | frame_start;
    underrun_d    = underrun_q;
    frame_err_d   = frame_err_q;
    frame_done_d  = 1'b0;
    psram_req_d   = psram_req_q;
    psram_addr_d  = psram_addr_q;

    case (state_q)
      S_IDLE: state_d = S_WAIT;

      S_WAIT: begin
        if (resync_pend_d) begin
          resync_pend_d = 1'b0;
          if (word_cnt_q != '0) begin
            word_cnt_d  = '0;
            frame_err_d = 1'b1;
          end else begin
            underrun_d  = 1'b0;
            frame_err_d = 1'b0;
          end
        end
        if (enable && !bus.fifo_prog_empty) begin
          state_d      = S_REQ;
          psram_req_d  = 1'b1;
          psram_addr_d = w_base + ADDR_W'(word_cnt_d);
        end
      end

      S_REQ: begin
        if (bus.psram_ack) begin
          psram_req_d = 1'b0;
          rd_left_d   = RD_W'(BURST_LEN);
          state_d     = S_BURST;
        end
      end

      S_BURST: begin
        if (w_ren) begin
          rd_left_d = rd_left_q - RD_W'(1);
        end
        if ((rd_left_q != '0) && bus.fifo_rempty) begin
          underrun_d = 1'b1;
        end
        if ((rd_left_q == '0) && (occ_q == 2'd0) && !inflight_q) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Frame completion takes precedence over a pending resync.
        if (w_next_cnt == CNT_W'(FRAME_WORDS)) begin
          word_cnt_d    = '0;
          frame_done_d  = 1'b1;
          resync_pend_d = 1'b0;
`ifdef PSRAM_PINGPONG_EN
          buf_sel_d     = ~buf_sel_q;
`else
          buf_sel_d     = 1'b0;
`endif
        end else if (resync_pend_d) begin
          word_cnt_d    = '0;
          frame_err_d   = 1'b1;
          resync_pend_d = 1'b0;
        end else begin
          word_cnt_d    = w_next_cnt;
        end
        state_d = S_WAIT;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    skid_d[0]  = skid_q[0];
    skid_d[1]  = skid_q[1];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = w_ren;
    if (w_push) begin
      skid_d[wr_ptr_q] = bus.fifo_rdata;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (w_pop_buf) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, w_push} - {1'b0, w_pop_buf};
  end

  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      word_cnt_q    <= '0;
      rd_left_q     <= '0;
      buf_sel_q     <= 1'b0;
      resync_pend_q <= 1'b0;
      underrun_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      psram_req_q   <= 1'b0;
      psram_addr_q  <= '0;
      skid_q[0]     <= 16'h0000;
      skid_q[1]     <= 16'h0000;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      occ_q         <= 2'd0;
      inflight_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      rd_left_q     <= rd_left_d;
      buf_sel_q     <= buf_sel_d;
      resync_pend_q <= resync_pend_d;
      underrun_q    <= underrun_d;
      frame_err_q   <= frame_err_d;
      frame_done_q  <= frame_done_d;
      psram_req_q   <= psram_req_d;
      psram_addr_q  <= psram_addr_d;
      skid_q[0]     <= skid_d[0];
      skid_q[1]     <= skid_d[1];
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      inflight_q    <= inflight_d;
    end
  end

  assign bus.fifo_ren     = w_ren;
  assign bus.psram_req    = psram_req_q;
  assign bus.psram_addr   = psram_addr_q;
  assign bus.psram_wdata  = w_wdata;
  assign bus.psram_wvalid = w_wvalid;
  assign buf_sel          = buf_sel_q;
  assign frame_done       = frame_done_q;
  assign underrun         = underrun_q;
  assign frame_err        = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_wr_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_psram_wr_burst_sched
// Purpose  : Directed bench for psram_wr_burst_sched with a FIFO/controller model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psram_wr_burst_sched;
  localparam int BL = 4;
  localparam int AW = 23;
  localparam int FW = 16;
  localparam int B0 = 0;
  localparam int B1 = 524288;
`ifdef PSRAM_PINGPONG_EN
  localparam int EXP_B1  = B1;
  localparam bit EXP_TOG = 1'b1;
`else
  localparam int EXP_B1  = B0;
  localparam bit EXP_TOG = 1'b0;
`endif

  logic rclk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic frame_start = 1'b0;
  logic buf_sel, frame_done, underrun, frame_err;

  psram_wr_burst_sched_if #(.ADDR_W(AW)) bus ();

  psram_wr_burst_sched #(
    .BURST_LEN(BL), .ADDR_W(AW), .FRAME_WORDS(FW), .BASE0(B0), .BASE1(B1)
  ) dut (
    .rclk(rclk), .reset_n(reset_n), .enable(enable), .frame_start(frame_start),
    .bus(bus), .buf_sel(buf_sel), .frame_done(frame_done),
    .underrun(underrun), .frame_err(frame_err)
  );

  always #5 rclk = ~rclk;

  int vectors = 0;
  int miscompares = 0;

  // FIFO model: data appears on fifo_rdata the cycle after fifo_ren.
  logic [15:0] fifo_q [$];
  int          fifo_n = 0;
  logic        push_en = 1'b0;
  logic [15:0] push_dat = 16'h0;
  logic        ren_s = 1'b0;
  logic        pe_force = 1'b0;
  logic [15:0] rdata_r = 16'h0;
  logic [15:0] pop_tmp;

  assign bus.fifo_rdata      = rdata_r;
  assign bus.fifo_rempty     = (fifo_n == 0);
  assign bus.fifo_prog_empty = (fifo_n < BL) && !pe_force;

  always @(negedge rclk) ren_s <= bus.fifo_ren;

  always @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q.delete();
      fifo_n  <= 0;
      rdata_r <= 16'h0;
    end else begin
      if (ren_s && fifo_q.size() > 0) begin
        pop_tmp = fifo_q.pop_front();
        rdata_r <= pop_tmp;
      end
      if (push_en) fifo_q.push_back(push_dat);
      fifo_n <= fifo_q.size();
    end
  end

  // Controller model: acks immediately when allowed, optional wready toggling.
  logic ack_en = 1'b1;
  logic bp_mode = 1'b0;
  logic ack_r = 1'b0;
  logic wready_r = 1'b1;
  assign bus.psram_ack    = ack_r;
  assign bus.psram_wready = wready_r;

  always @(posedge rclk) begin
    #1;
    ack_r    = ack_en && bus.psram_req;
    wready_r = bp_mode ? ~wready_r : 1'b1;
  end

  logic [15:0]   beat_d [$];
  int            beat_cyc [$];
  logic [AW-1:0] req_a [$];
  int            fd_cnt = 0;
  int            fd_long = 0;
  logic          fd_prev = 1'b0;
  int            cyc = 0;

  always @(negedge rclk) begin
    cyc++;
    if (reset_n) begin
      if (bus.psram_wvalid && bus.psram_wready) begin
        beat_d.push_back(bus.psram_wdata);
        beat_cyc.push_back(cyc);
      end
      if (bus.psram_req && bus.psram_ack) req_a.push_back(bus.psram_addr);
      if (frame_done) fd_cnt++;
      if (frame_done && fd_prev) fd_long++;
      fd_prev = frame_done;
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_words(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      push_en  = 1'b1;
      push_dat = first + 16'(i);
      tick();
    end
    push_en = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (beat_d.size() < n && k < 300) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_reqs(input int n);
    int k;
    k = 0;
    while (req_a.size() < n && k < 300) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    reset_n = 1'b0;
    repeat (3) tick();
    flags = {bus.psram_req, bus.fifo_ren, bus.psram_wvalid, buf_sel, frame_done, underrun, frame_err};
    vectors++;
    if (flags !== 7'b0) begin
      $display("FAIL reset_flags: got %b want 0000000", flags); miscompares++;
    end
    vectors++;
    if (bus.psram_wdata !== 16'h0 || bus.psram_addr !== '0) begin
      $display("FAIL reset_data: wdata %h addr %h want 0/0", bus.psram_wdata, bus.psram_addr); miscompares++;
    end
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (5) tick();
    vectors++;
    if (bus.psram_req !== 1'b0 || req_a.size() != 0) begin
      $display("FAIL idle_no_req: req %b count %0d want 0/0", bus.psram_req, req_a.size()); miscompares++;
    end
  endtask

  task automatic test_basic();
    int k;
    ack_en = 1'b0;
    push_words(16'h0001, 4);
    k = 0;
    while (bus.psram_req !== 1'b1 && k < 50) begin tick(); k++; end
    repeat (6) tick();
    vectors++;
    if (bus.psram_req !== 1'b1 || bus.psram_addr !== AW'(B0) || beat_d.size() != 0) begin
      $display("FAIL req_hold: req %b addr %h beats %0d want 1/%h/0",
               bus.psram_req, bus.psram_addr, beat_d.size(), AW'(B0)); miscompares++;
    end
    ack_en = 1'b1;
    wait_beats(4);
    vectors++;
    if (req_a.size() < 1 || req_a[0] !== AW'(B0)) begin
      $display("FAIL basic_addr0: got %h want %h", (req_a.size() > 0) ? req_a[0] : '1, AW'(B0)); miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (beat_d.size() <= i || beat_d[i] !== 16'(i + 1)) begin
        $display("FAIL basic_data[%0d]: got %h want %h", i, (beat_d.size() > i) ? beat_d[i] : 16'hxxxx, 16'(i + 1)); miscompares++;
      end
    end
    vectors++;
    if (beat_cyc.size() < 4 || (beat_cyc[3] - beat_cyc[0]) != 3) begin
      $display("FAIL basic_rate: beat span %0d want 3", (beat_cyc.size() >= 4) ? beat_cyc[3] - beat_cyc[0] : -1); miscompares++;
    end
    push_words(16'h0005, 4);
    wait_beats(8);
    repeat (4) tick();
    vectors++;
    if (req_a.size() < 2 || req_a[1] !== AW'(B0 + 4)) begin
      $display("FAIL basic_addr1: got %h want %h", (req_a.size() > 1) ? req_a[1] : '1, AW'(B0 + 4)); miscompares++;
    end
    vectors++;
    if (beat_d.size() != 8 || beat_d[7] !== 16'h0008) begin
      $display("FAIL basic_burst2: beats %0d last %h want 8/0008", beat_d.size(), (beat_d.size() > 7) ? beat_d[7] : 16'hxxxx); miscompares++;
    end
    vectors++;
    if (underrun !== 1'b0 || fd_cnt != 0) begin
      $display("FAIL basic_flags: underrun %b frame_done %0d want 0/0", underrun, fd_cnt); miscompares++;
    end
  endtask

  task automatic test_backpressure();
    bp_mode = 1'b1;
    push_words(16'h0011, 4);
    wait_beats(12);
    repeat (6) tick();
    bp_mode = 1'b0;
    vectors++;
    if (beat_d.size() != 12) begin
      $display("FAIL bp_beats: got %0d want 12", beat_d.size()); miscompares++;
    end
    vectors++;
    if (req_a.size() < 3 || req_a[2] !== AW'(B0 + 8)) begin
      $display("FAIL bp_addr: got %h want %h", (req_a.size() > 2) ? req_a[2] : '1, AW'(B0 + 8)); miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (beat_d.size() <= 8 + i || beat_d[8 + i] !== 16'(16'h0011 + i)) begin
        $display("FAIL bp_data[%0d]: got %h want %h", i, (beat_d.size() > 8 + i) ? beat_d[8 + i] : 16'hxxxx, 16'(16'h0011 + i)); miscompares++;
      end
    end
  endtask

  task automatic test_frame_wrap();
    push_words(16'h0021, 4);
    wait_beats(16);
    repeat (4) tick();
    vectors++;
    if (req_a.size() < 4 || req_a[3] !== AW'(B0 + 12)) begin
      $display("FAIL wrap_last_addr: got %h want %h", (req_a.size() > 3) ? req_a[3] : '1, AW'(B0 + 12)); miscompares++;
    end
    vectors++;
    if (fd_cnt != 1 || fd_long != 0 || buf_sel !== EXP_TOG) begin
      $display("FAIL wrap_done1: frame_done %0d long %0d buf_sel %b want 1/0/%b", fd_cnt, fd_long, buf_sel, EXP_TOG); miscompares++;
    end
    push_words(16'h0031, 16);
    wait_beats(32);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (req_a.size() <= 4 + i || req_a[4 + i] !== AW'(EXP_B1 + 4 * i)) begin
        $display("FAIL wrap_buf1_addr[%0d]: got %h want %h", i, (req_a.size() > 4 + i) ? req_a[4 + i] : '1, AW'(EXP_B1 + 4 * i)); miscompares++;
      end
    end
    vectors++;
    if (beat_d.size() != 32 || beat_d[16] !== 16'h0031 || beat_d[31] !== 16'h0040) begin
      $display("FAIL wrap_data: beats %0d want 32 with 0031..0040", beat_d.size()); miscompares++;
    end
    vectors++;
    if (fd_cnt != 2 || fd_long != 0 || buf_sel !== 1'b0) begin
      $display("FAIL wrap_done2: frame_done %0d long %0d buf_sel %b want 2/0/0", fd_cnt, fd_long, buf_sel); miscompares++;
    end
    push_words(16'h0041, 4);
    wait_beats(36);
    vectors++;
    if (req_a.size() < 9 || req_a[8] !== AW'(B0)) begin
      $display("FAIL wrap_back_addr: got %h want %h", (req_a.size() > 8) ? req_a[8] : '1, AW'(B0)); miscompares++;
    end
  endtask

  task automatic test_underrun();
    push_words(16'h0051, 2);
    pe_force = 1'b1;
    wait_reqs(10);
    pe_force = 1'b0;
    repeat (10) tick();
    vectors++;
    if (req_a.size() < 10 || req_a[9] !== AW'(B0 + 4)) begin
      $display("FAIL ur_addr: got %h want %h", (req_a.size() > 9) ? req_a[9] : '1, AW'(B0 + 4)); miscompares++;
    end
    vectors++;
    if (underrun !== 1'b1 || beat_d.size() != 38) begin
      $display("FAIL ur_stall: underrun %b beats %0d want 1/38", underrun, beat_d.size()); miscompares++;
    end
    vectors++;
    if (bus.fifo_ren !== 1'b0 || bus.psram_wvalid !== 1'b0) begin
      $display("FAIL ur_idle: ren %b wvalid %b want 0/0", bus.fifo_ren, bus.psram_wvalid); miscompares++;
    end
    push_words(16'h0053, 2);
    wait_beats(40);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (beat_d.size() <= 36 + i || beat_d[36 + i] !== 16'(16'h0051 + i)) begin
        $display("FAIL ur_data[%0d]: got %h want %h", i, (beat_d.size() > 36 + i) ? beat_d[36 + i] : 16'hxxxx, 16'(16'h0051 + i)); miscompares++;
      end
    end
    vectors++;
    if (underrun !== 1'b1 || req_a.size() != 10) begin
      $display("FAIL ur_sticky: underrun %b reqs %0d want 1/10", underrun, req_a.size()); miscompares++;
    end
  endtask

  task automatic test_resync();
    push_words(16'h0061, 4);
    wait_reqs(11);
    repeat (2) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_beats(44);
    repeat (4) tick();
    vectors++;
    if (req_a.size() < 11 || req_a[10] !== AW'(B0 + 8)) begin
      $display("FAIL rs_addr: got %h want %h", (req_a.size() > 10) ? req_a[10] : '1, AW'(B0 + 8)); miscompares++;
    end
    vectors++;
    if (beat_d.size() != 44 || beat_d[43] !== 16'h0064) begin
      $display("FAIL rs_burst: beats %0d want 44 ending 0064", beat_d.size()); miscompares++;
    end
    vectors++;
    if (frame_err !== 1'b1 || underrun !== 1'b1 || fd_cnt != 2) begin
      $display("FAIL rs_err: frame_err %b underrun %b frame_done %0d want 1/1/2", frame_err, underrun, fd_cnt); miscompares++;
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (3) tick();
    vectors++;
    if (frame_err !== 1'b0 || underrun !== 1'b0) begin
      $display("FAIL rs_clear: frame_err %b underrun %b want 0/0", frame_err, underrun); miscompares++;
    end
    push_words(16'h0071, 4);
    wait_beats(48);
    repeat (3) tick();
    vectors++;
    if (req_a.size() < 12 || req_a[11] !== AW'(B0)) begin
      $display("FAIL rs_next_addr: got %h want %h", (req_a.size() > 11) ? req_a[11] : '1, AW'(B0)); miscompares++;
    end
    vectors++;
    if (fd_cnt != 2 || frame_err !== 1'b0) begin
      $display("FAIL rs_after: frame_done %0d frame_err %b want 2/0", fd_cnt, frame_err); miscompares++;
    end
  endtask

  task automatic test_async_reset();
    int n0;
    logic [6:0] flags;
    push_words(16'h0081, 4);
    wait_reqs(13);
    repeat (2) tick();
    vectors++;
    if (bus.psram_wvalid !== 1'b1) begin
      $display("FAIL ar_midburst: wvalid %b want 1", bus.psram_wvalid); miscompares++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    flags = {bus.psram_req, bus.fifo_ren, bus.psram_wvalid, buf_sel, frame_done, underrun, frame_err};
    vectors++;
    if (flags !== 7'b0 || bus.psram_wdata !== 16'h0 || bus.psram_addr !== '0) begin
      $display("FAIL ar_outputs: flags %b wdata %h addr %h want all 0", flags, bus.psram_wdata, bus.psram_addr); miscompares++;
    end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    n0 = beat_d.size();
    push_words(16'h0091, 4);
    wait_beats(n0 + 4);
    repeat (3) tick();
    vectors++;
    if (req_a.size() < 14 || req_a[13] !== AW'(B0)) begin
      $display("FAIL ar_addr: got %h want %h", (req_a.size() > 13) ? req_a[13] : '1, AW'(B0)); miscompares++;
    end
    vectors++;
    if (beat_d.size() != n0 + 4 || beat_d[n0] !== 16'h0091 || beat_d[n0 + 3] !== 16'h0094) begin
      $display("FAIL ar_data: beats %0d want %0d with 0091..0094", beat_d.size(), n0 + 4); miscompares++;
    end
    vectors++;
    if (buf_sel !== 1'b0) begin
      $display("FAIL ar_buf_sel: got %b want 0", buf_sel); miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_frame_wrap();
    test_underrun();
    test_resync();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
